// File: rtl/v_rams_reader.sv
// ---------------------------------------------------------------------------
// v_rams_reader
//   Burst read sequencer for the read port of a block RAM with a registered
//   read address. A start request loads a base address and a word count.
//   The sequencer then presents consecutive addresses (wrapping modulo the
//   RAM depth), captures each returned word into a 4-entry output FIFO, and
//   streams the words out on a valid/ready interface with full back-pressure.
//
//   Optional feature macro: RAMS_READER_PARITY_EN
//     When defined, adds output dout_par = ^dout (even parity), stored with
//     each FIFO entry so it stays stable under back-pressure exactly like dout.
//
// Ports
//   clk         in   1       clock, all logic on posedge
//   rst         in   1       asynchronous reset, active-high
//   start       in   1       burst request, sampled only in IDLE
//   base_addr   in   AWIDTH  first read address, sampled with start
//   len         in   LWIDTH  words to read, sampled with start; 0 = empty burst
//   busy        out  1       high from accepted start until done
//   done        out  1       one-cycle pulse when the burst is complete
//   ram_addr    out  AWIDTH  registered address to the RAM read port
//   ram_do      in   DWIDTH  RAM read data, valid the cycle after ram_addr
//   dout        out  DWIDTH  output word
//   dout_par    out  1       even parity of dout (RAMS_READER_PARITY_EN only)
//   dout_valid  out  1       dout holds a valid word
//   dout_ready  in   1       sink accepts dout this cycle
//   dout_last   out  1       marks the final word of the burst
// ---------------------------------------------------------------------------
module v_rams_reader #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 7,
  parameter int LWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AWIDTH-1:0] base_addr,
  input  logic [LWIDTH-1:0] len,
  output logic              busy,
  output logic              done,
  output logic [AWIDTH-1:0] ram_addr,
  input  logic [DWIDTH-1:0] ram_do,
  output logic [DWIDTH-1:0] dout,
`ifdef RAMS_READER_PARITY_EN
  output logic              dout_par,
`endif
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_last
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_FIN   = 2'd3;

  logic [1:0]        state;
  // issue_q: ram_addr carries a real read this cycle.
  // flight_q: ram_do carries the word for a read issued last cycle.
  logic              issue_q;
  logic              flight_q;
  logic [LWIDTH-1:0] issue_left;
  logic [LWIDTH-1:0] push_left;
  logic [LWIDTH-1:0] pop_left;

  logic [DWIDTH-1:0] mem_data [4];
  logic [3:0]        mem_last;
  logic [1:0]        wr_ptr;
  logic [1:0]        rd_ptr;
  logic [2:0]        count;

  logic              push;
  logic              pop;
  logic [2:0]        count_next;
  logic [3:0]        occupancy;
  logic              can_issue;

  // An issue is only granted when every word already committed (buffered,
  // returning from the RAM, or being read right now) plus the new one still
  // fits in the FIFO, so the FIFO can never overflow under back-pressure.
  always_comb begin
    push       = flight_q;
    pop        = dout_valid & dout_ready;
    count_next = count + {2'b00, push} - {2'b00, pop};
    occupancy  = {1'b0, count_next} + {3'b000, issue_q};
    can_issue  = occupancy < 4'd4;
  end

  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_FIN);
  assign dout_valid = (count != 3'd0);
  assign dout       = mem_data[rd_ptr];
  assign dout_last  = mem_last[rd_ptr];

  // Control FSM and address generator. Every address after the first is the
  // previous one plus one, so a stalled issue simply holds ram_addr and the
  // increment happens when the issue is finally granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      ram_addr   <= '0;
      issue_q    <= 1'b0;
      flight_q   <= 1'b0;
      issue_left <= '0;
      push_left  <= '0;
      pop_left   <= '0;
    end else begin
      flight_q <= issue_q;
      if (push) push_left <= push_left - LWIDTH'(1);
      if (pop)  pop_left  <= pop_left - LWIDTH'(1);
      case (state)
        ST_IDLE: begin
          issue_q <= 1'b0;
          if (start) begin
            if (len == '0) begin
              state <= ST_FIN;
            end else begin
              state      <= ST_RUN;
              ram_addr   <= base_addr;
              issue_q    <= 1'b1;
              issue_left <= len - LWIDTH'(1);
              push_left  <= len;
              pop_left   <= len;
            end
          end
        end
        ST_RUN: begin
          if (issue_left == '0) begin
            state   <= ST_DRAIN;
            issue_q <= 1'b0;
          end else if (can_issue) begin
            ram_addr   <= ram_addr + AWIDTH'(1);
            issue_q    <= 1'b1;
            issue_left <= issue_left - LWIDTH'(1);
          end else begin
            issue_q <= 1'b0;
          end
        end
        ST_DRAIN: begin
          issue_q <= 1'b0;
          if (pop && pop_left == LWIDTH'(1)) state <= ST_FIN;
        end
        default: begin
          issue_q <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  // Output FIFO. The last flag is attached at push time from the count of
  // words still expected, so dout_last travels with its word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) mem_data[i] <= '0;
      mem_last <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= ram_do;
        mem_last[wr_ptr] <= (push_left == LWIDTH'(1));
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      count <= count_next;
    end
  end

`ifdef RAMS_READER_PARITY_EN
  logic [3:0] mem_par;

  // Parity is computed on the way in and stored beside each word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_par <= '0;
    end else if (push) begin
      mem_par[wr_ptr] <= ^ram_do;
    end
  end

  assign dout_par = mem_par[rd_ptr];
`endif

endmodule
